// File: rtl/reg_file_arb.sv
// Two-requester arbiter in front of a single-ported 8 x 8-bit register file.
// Optional macro ARB_FIXED_PRIO_EN: requester A always wins ties (default is round-robin).
module reg_file_arb (
    input  logic       CLK,
    input  logic       RST,
    input  logic       A_REQ,
    input  logic       A_WE,
    input  logic [2:0] A_ADDR,
    input  logic [7:0] A_WDATA,
    output logic       A_GNT,
    output logic       A_RVALID,
    output logic [7:0] A_RDATA,
    input  logic       B_REQ,
    input  logic       B_WE,
    input  logic [2:0] B_ADDR,
    input  logic [7:0] B_WDATA,
    output logic       B_GNT,
    output logic       B_RVALID,
    output logic [7:0] B_RDATA,
    output logic [2:0] BUS_ADDR,
    output logic [7:0] BUS_DIN,
    output logic       BUS_WEN,
    output logic       BUS_OEN,
    input  logic [7:0] BUS_DOUT,
    output logic       BUSY
);
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                pick_b;
    logic                win;
    logic                win_nxt;
    logic                wr;
    logic                wr_nxt;
    logic                a_gnt_nxt;
    logic                b_gnt_nxt;
    logic                a_rv_nxt;
    logic                b_rv_nxt;
    logic [DATA_W-1:0]   a_rdata_nxt;
    logic [DATA_W-1:0]   b_rdata_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   din_nxt;
    logic                wen_nxt;
    logic                oen_nxt;
    logic                busy_nxt;

    assign accept = (state == IDLE) && (A_REQ || B_REQ);

`ifdef ARB_FIXED_PRIO_EN
    assign pick_b = B_REQ && !A_REQ;
`else
    // last winner: 0 = A, 1 = B; resetting to B makes A win the first tie
    logic last;

    assign pick_b = B_REQ && (!A_REQ || !last);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= pick_b;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = wr ? IDLE : RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // next values for the registered outputs; bus address/data and read data hold by default
    always_comb begin
        win_nxt     = win;
        wr_nxt      = wr;
        addr_nxt    = BUS_ADDR;
        din_nxt     = BUS_DIN;
        a_rdata_nxt = A_RDATA;
        b_rdata_nxt = B_RDATA;
        a_gnt_nxt   = 1'b0;
        b_gnt_nxt   = 1'b0;
        a_rv_nxt    = 1'b0;
        b_rv_nxt    = 1'b0;
        wen_nxt     = 1'b0;
        oen_nxt     = 1'b0;
        busy_nxt    = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    win_nxt   = pick_b;
                    wr_nxt    = pick_b ? B_WE    : A_WE;
                    addr_nxt  = pick_b ? B_ADDR  : A_ADDR;
                    din_nxt   = pick_b ? B_WDATA : A_WDATA;
                    wen_nxt   = wr_nxt;
                    oen_nxt   = !wr_nxt;
                    a_gnt_nxt = !pick_b;
                    b_gnt_nxt = pick_b;
                end
            end
            RESP: begin
                if (win) begin
                    b_rdata_nxt = BUS_DOUT;
                    b_rv_nxt    = 1'b1;
                end else begin
                    a_rdata_nxt = BUS_DOUT;
                    a_rv_nxt    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            win      <= 1'b0;
            wr       <= 1'b0;
            A_GNT    <= 1'b0;
            B_GNT    <= 1'b0;
            A_RVALID <= 1'b0;
            B_RVALID <= 1'b0;
            A_RDATA  <= '0;
            B_RDATA  <= '0;
            BUS_ADDR <= '0;
            BUS_DIN  <= '0;
            BUS_WEN  <= 1'b0;
            BUS_OEN  <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            win      <= win_nxt;
            wr       <= wr_nxt;
            A_GNT    <= a_gnt_nxt;
            B_GNT    <= b_gnt_nxt;
            A_RVALID <= a_rv_nxt;
            B_RVALID <= b_rv_nxt;
            A_RDATA  <= a_rdata_nxt;
            B_RDATA  <= b_rdata_nxt;
            BUS_ADDR <= addr_nxt;
            BUS_DIN  <= din_nxt;
            BUS_WEN  <= wen_nxt;
            BUS_OEN  <= oen_nxt;
            BUSY     <= busy_nxt;
        end
    end

endmodule
